// File: rtl/pc_ret_stack16_if.sv
// Control/status bundle between the control unit and the PC sequencer.
// Optional wrap flag exists only when PC_WRAP_TRAP_EN is defined.
interface pc_ret_stack16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             clr;
  logic             ret;
  logic             call;
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] out;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;
`ifdef PC_WRAP_TRAP_EN
  logic             wrap;
`endif

`ifdef PC_WRAP_TRAP_EN
  modport master (
    output in, clr, ret, call, load, inc,
    input  out, stk_full, stk_empty, stk_err, wrap
  );
  modport slave (
    input  in, clr, ret, call, load, inc,
    output out, stk_full, stk_empty, stk_err, wrap
  );
`else
  modport master (
    output in, clr, ret, call, load, inc,
    input  out, stk_full, stk_empty, stk_err
  );
  modport slave (
    input  in, clr, ret, call, load, inc,
    output out, stk_full, stk_empty, stk_err
  );
`endif
endinterface

// File: rtl/pc_ret_stack16.sv
// PC sequencer with clear/jump/increment/hold and a small return-address stack.
// Define PC_WRAP_TRAP_EN to add the sticky wrap flag on the interface.
module pc_ret_stack16 #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_ret_stack16_if.slave  bus
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_RET,
    ACT_CALL,
    ACT_LOAD,
    ACT_INC
  } action_t;

  action_t          action;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             err_q;
  logic             err_d;
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] top_idx;
  logic             push_en;
  logic             is_full;
  logic             is_empty;
  logic             pc_all_ones;

  assign pc_plus1    = pc_q + WIDTH'(1);
  assign pc_all_ones = &pc_q;
  assign is_full     = (count_q == CNT_W'(STACK_DEPTH));
  assign is_empty    = (count_q == '0);
  // Low pointer bits wrap to 0 at full, so top = ptr-1 stays correct there too.
  assign push_idx    = count_q[PTR_W-1:0];
  assign top_idx     = count_q[PTR_W-1:0] - PTR_W'(1);

  // Resolve the single winning action for this cycle by fixed priority.
  always_comb begin
    action = ACT_HOLD;
    if (bus.clr)       action = ACT_CLR;
    else if (bus.ret)  action = ACT_RET;
    else if (bus.call) action = ACT_CALL;
    else if (bus.load) action = ACT_LOAD;
    else if (bus.inc)  action = ACT_INC;
  end

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
    push_en = 1'b0;
    case (action)
      ACT_CLR: begin
        pc_d    = '0;
        count_d = '0;
        err_d   = 1'b0;
      end
      ACT_RET: begin
        if (is_empty) begin
          err_d = 1'b1;
        end else begin
          pc_d    = stack_mem[top_idx];
          count_d = count_q - CNT_W'(1);
        end
      end
      ACT_CALL: begin
        if (is_full) begin
          err_d = 1'b1;
        end else begin
          push_en = 1'b1;
          pc_d    = bus.in;
          count_d = count_q + CNT_W'(1);
        end
      end
      ACT_LOAD: pc_d = bus.in;
      ACT_INC:  pc_d = pc_plus1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry contents need no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[push_idx] <= pc_plus1;
  end

`ifdef PC_WRAP_TRAP_EN
  logic wrap_q;
  logic wrap_d;

  // Only an actual increment or an actual push can wrap; overflowed calls cannot.
  always_comb begin
    wrap_d = wrap_q;
    if (action == ACT_CLR)
      wrap_d = 1'b0;
    else if ((action == ACT_INC || push_en) && pc_all_ones)
      wrap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign bus.wrap = wrap_q;
`else
  logic unused_all_ones;
  assign unused_all_ones = pc_all_ones;
`endif

  assign bus.out       = pc_q;
  assign bus.stk_full  = is_full;
  assign bus.stk_empty = is_empty;
  assign bus.stk_err   = err_q;

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(STACK_DEPTH));

endmodule

// File: tb/tb_pc_ret_stack16.sv
// Self-checking bench for pc_ret_stack16: directed scenarios plus random
// control streams checked against a queue-based reference model.
module tb_pc_ret_stack16;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  bit [15:0] m_pc;
  bit [15:0] m_stack[$];
  bit        m_err;
  bit        m_wrap;

  pc_ret_stack16_if #(.WIDTH(WIDTH)) bus ();

  pc_ret_stack16 #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = '0;
    m_stack.delete();
    m_err = 1'b0;
    m_wrap = 1'b0;
  endtask

  // Reference behaviour: one action per cycle, highest-priority control wins.
  task automatic model_step(input bit c_clr, c_ret, c_call, c_load, c_inc,
                            input bit [15:0] target);
    if (c_clr) begin
      model_reset();
    end else if (c_ret) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_pc = m_stack.pop_back();
    end else if (c_call) begin
      if (m_stack.size() == DEPTH) begin
        m_err = 1'b1;
      end else begin
        if (m_pc == 16'hFFFF) m_wrap = 1'b1;
        m_stack.push_back(m_pc + 16'd1);
        m_pc = target;
      end
    end else if (c_load) begin
      m_pc = target;
    end else if (c_inc) begin
      if (m_pc == 16'hFFFF) m_wrap = 1'b1;
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic applyStimulus(input bit c_clr, c_ret, c_call, c_load, c_inc,
                               input bit [15:0] target);
    bus.clr  = c_clr;
    bus.ret  = c_ret;
    bus.call = c_call;
    bus.load = c_load;
    bus.inc  = c_inc;
    bus.in   = target;
    @(posedge clk);
    #1;
    model_step(c_clr, c_ret, c_call, c_load, c_inc, target);
    bus.clr  = 1'b0;
    bus.ret  = 1'b0;
    bus.call = 1'b0;
    bus.load = 1'b0;
    bus.inc  = 1'b0;
  endtask

  task automatic test_reset();
    bit [15:0] exp_pc;
    rst_n = 1'b0;
    bus.clr = 0; bus.ret = 0; bus.call = 0; bus.load = 0; bus.inc = 0;
    bus.in = '0;
    model_reset();
    #12;
    n_cmp++;
    if (bus.out !== 16'h0000 || bus.stk_empty !== 1'b1 || bus.stk_full !== 1'b0 ||
        bus.stk_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: out=%h empty=%b full=%b err=%b, want 0000 1 0 0",
               bus.out, bus.stk_empty, bus.stk_full, bus.stk_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 16'h0);
      exp_pc = 16'(i);
      n_cmp++;
      if (bus.out !== exp_pc || bus.stk_empty !== 1'b1 || bus.stk_err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL inc_after_reset: out=%h empty=%b err=%b, want %h 1 0",
                 bus.out, bus.stk_empty, bus.stk_err, exp_pc);
      end
    end
  endtask

  task automatic test_call_ret();
    applyStimulus(0, 0, 0, 1, 0, 16'h0100);
    applyStimulus(0, 0, 1, 0, 0, 16'h2000);
    n_cmp++;
    if (bus.out !== 16'h2000 || bus.stk_empty !== 1'b0 || bus.stk_full !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL call_single: out=%h empty=%b full=%b, want 2000 0 0",
               bus.out, bus.stk_empty, bus.stk_full);
    end
    applyStimulus(0, 1, 0, 0, 0, 16'h0);
    n_cmp++;
    if (bus.out !== 16'h0101 || bus.stk_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ret_single: out=%h empty=%b, want 0101 1",
               bus.out, bus.stk_empty);
    end
  endtask

  task automatic test_nested();
    bit [15:0] exp_ret[4];
    exp_ret[0] = 16'h0031; exp_ret[1] = 16'h0021;
    exp_ret[2] = 16'h0011; exp_ret[3] = 16'h0006;
    applyStimulus(0, 0, 0, 1, 0, 16'h0005);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, 0, 0, 16'(i * 16));
    n_cmp++;
    if (bus.out !== 16'h0040 || bus.stk_full !== 1'b1 || bus.stk_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL nested_full: out=%h full=%b err=%b, want 0040 1 0",
               bus.out, bus.stk_full, bus.stk_err);
    end
    applyStimulus(0, 0, 1, 0, 0, 16'h0050);
    n_cmp++;
    if (bus.out !== 16'h0040 || bus.stk_err !== 1'b1 || bus.stk_full !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow_call: out=%h err=%b full=%b, want 0040 1 1",
               bus.out, bus.stk_err, bus.stk_full);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 16'h0);
      n_cmp++;
      if (bus.out !== exp_ret[i]) begin
        n_fail++;
        $display("[TB] FAIL nested_ret%0d: out=%h, want %h", i, bus.out, exp_ret[i]);
      end
    end
    n_cmp++;
    if (bus.stk_empty !== 1'b1 || bus.stk_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL nested_drained: empty=%b err=%b, want 1 1",
               bus.stk_empty, bus.stk_err);
    end
    applyStimulus(1, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic test_underflow();
    applyStimulus(0, 0, 0, 1, 0, 16'h0042);
    applyStimulus(0, 1, 0, 0, 0, 16'h0);
    n_cmp++;
    if (bus.out !== 16'h0042 || bus.stk_err !== 1'b1 || bus.stk_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL underflow_ret: out=%h err=%b empty=%b, want 0042 1 1",
               bus.out, bus.stk_err, bus.stk_empty);
    end
    applyStimulus(0, 0, 0, 0, 1, 16'h0);
    n_cmp++;
    if (bus.out !== 16'h0043 || bus.stk_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_sticky: out=%h err=%b, want 0043 1", bus.out, bus.stk_err);
    end
  endtask

  task automatic test_priority();
    applyStimulus(0, 0, 1, 0, 0, 16'h1234);
    applyStimulus(1, 1, 1, 1, 1, 16'h5555);
    n_cmp++;
    if (bus.out !== 16'h0000 || bus.stk_empty !== 1'b1 || bus.stk_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clr_priority: out=%h empty=%b err=%b, want 0000 1 0",
               bus.out, bus.stk_empty, bus.stk_err);
    end
    applyStimulus(0, 0, 1, 0, 0, 16'h0200);
    applyStimulus(0, 1, 1, 1, 1, 16'h0777);
    n_cmp++;
    if (bus.out !== 16'h0001 || bus.stk_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ret_priority: out=%h empty=%b, want 0001 1",
               bus.out, bus.stk_empty);
    end
    applyStimulus(0, 0, 0, 1, 1, 16'h0ABC);
    n_cmp++;
    if (bus.out !== 16'h0ABC) begin
      n_fail++;
      $display("[TB] FAIL load_over_inc: out=%h, want 0abc", bus.out);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(0, 0, 0, 1, 0, 16'hFFFF);
    applyStimulus(0, 0, 0, 0, 1, 16'h0);
    n_cmp++;
    if (bus.out !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL inc_wrap: out=%h, want 0000", bus.out);
    end
`ifdef PC_WRAP_TRAP_EN
    n_cmp++;
    if (bus.wrap !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrap_flag: wrap=%b, want 1", bus.wrap);
    end
`endif
    applyStimulus(0, 0, 0, 1, 0, 16'hFFFF);
    applyStimulus(0, 0, 1, 0, 0, 16'h0300);
    applyStimulus(0, 1, 0, 0, 0, 16'h0);
    n_cmp++;
    if (bus.out !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL call_wrap_ret: out=%h, want 0000", bus.out);
    end
    applyStimulus(0, 0, 0, 1, 0, 16'h0777);
    applyStimulus(0, 1, 0, 0, 0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out !== 16'h0000 || bus.stk_err !== 1'b0 || bus.stk_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL async_reset: out=%h err=%b empty=%b, want 0000 0 1",
               bus.out, bus.stk_err, bus.stk_empty);
    end
`ifdef PC_WRAP_TRAP_EN
    n_cmp++;
    if (bus.wrap !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_wrap: wrap=%b, want 0", bus.wrap);
    end
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit c_clr, c_ret, c_call, c_load, c_inc;
    bit [15:0] target;
    int local_fail;
    local_fail = 0;
    for (int i = 0; i < 600; i++) begin
      c_clr  = ($urandom_range(99) < 3);
      c_ret  = ($urandom_range(99) < 25);
      c_call = ($urandom_range(99) < 30);
      c_load = ($urandom_range(99) < 20);
      c_inc  = ($urandom_range(99) < 40);
      target = ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom);
      applyStimulus(c_clr, c_ret, c_call, c_load, c_inc, target);
      n_cmp++;
      if (bus.out !== m_pc || bus.stk_err !== m_err ||
          bus.stk_full !== (m_stack.size() == DEPTH) ||
          bus.stk_empty !== (m_stack.size() == 0)
`ifdef PC_WRAP_TRAP_EN
          || bus.wrap !== m_wrap
`endif
          ) begin
        n_fail++;
        local_fail++;
        if (local_fail <= 10)
          $display("[TB] FAIL random_step%0d: out=%h err=%b full=%b empty=%b, want %h %b %b %b",
                   i, bus.out, bus.stk_err, bus.stk_full, bus.stk_empty,
                   m_pc, m_err, m_stack.size() == DEPTH, m_stack.size() == 0);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_call_ret();
    test_nested();
    test_underflow();
    test_priority();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
